beat_recorder_ctrl: RTL and testbench
=====================================

Name: beat_recorder_ctrl

Overview:
Multi-slot beat recording engine for the Beat Recorder top level. It captures a note code on every sample tick into one of NUM_SLOTS recording slots, then plays a slot back at the same tick rate. Record, play and clear-all are one-cycle pulses from the debounced KEY logic. Slot selection comes from the switches. Note output drives the sound-device path.

Parameters:
NUM_SLOTS, 8, number of saved-recording slots (power of 2, >=2)
DEPTH, 256, samples per slot (power of 2, >=4)
NOTE_W, 8, note code width; 0 = silence

Ports:
CLOCK_50  input  1  system clock; all logic is rising-edge
resetn  input  1  asynchronous active-low reset
tick  input  1  one-cycle sample strobe from the tempo divider
rec_pulse  input  1  one-cycle pulse: start recording, or stop if already recording
play_pulse  input  1  one-cycle pulse: start playback, or stop if already playing
clear_pulse  input  1  one-cycle pulse: erase all slot lengths
slot_sel  input  clog2(NUM_SLOTS)  slot chosen by the switches
note_in  input  NOTE_W  live note code from the keyboard decoder
note_out  output  NOTE_W  playback note code, registered
note_valid  output  1  one-cycle strobe; note_out was updated this cycle
recording  output  1  high in RECORD
playing  output  1  high in PLAY
active_slot  output  clog2(NUM_SLOTS)  slot latched at operation start
cur_len  output  clog2(DEPTH)+1  stored length of slot_sel, registered
done  output  1  one-cycle pulse on a natural end (slot full, or playback reached its length)

Behaviour:
- Storage: RAM of NUM_SLOTS*DEPTH x NOTE_W, addressed {active_slot, ptr}. Per-slot length register len[s], range 0..DEPTH.
- Reset: all outputs 0, state IDLE, ptr 0, every len[s] 0. RAM contents are not reset.
- States: IDLE, RECORD, PLAY, CLEAR.
- IDLE: priority is clear > rec > play.
  - clear_pulse -> CLEAR.
  - rec_pulse -> RECORD; latch active_slot=slot_sel, ptr=0, len[slot]=0.
  - play_pulse with len[slot_sel]!=0 -> PLAY; latch active_slot, ptr=0.
  - play_pulse with len==0 is ignored.
- RECORD:
  - On tick: write note_in at ptr, ptr+=1, len[active_slot]=ptr+1.
  - After the write at ptr==DEPTH-1: go to IDLE and pulse done. len=DEPTH.
  - rec_pulse: go to IDLE, no done pulse, len keeps the count written so far.
  - tick and rec_pulse in the same cycle: the sample is written, then the block stops.
  - play_pulse is ignored.
  - clear_pulse aborts the recording -> CLEAR.
- PLAY:
  - On tick: RAM read at ptr. note_out and note_valid update 1 cycle after the tick (read latency 1).
  - ptr+=1 on each tick.
  - When the tick that reads index len-1 has been issued: the FSM returns to IDLE the following cycle, asserting done with that final note_valid.
  - play_pulse stops playback immediately with no done pulse.
  - rec_pulse is ignored.
  - clear_pulse -> CLEAR.
  - On any exit from PLAY, note_out is forced to 0 (silence) in the cycle after the last valid note.
- CLEAR: all len[s]=0 in one cycle, then IDLE. RAM is not erased.
- slot_sel changes during RECORD or PLAY are ignored; active_slot holds.
- cur_len = len[slot_sel] registered, so it lags by 1 cycle.
- ptr width is clog2(DEPTH)+1 and never wraps in RECORD.
- Asynchronous reset mid-operation returns to IDLE with all lengths 0.

Optional Feature:
LOOP_PLAY_EN.
- Defined: in PLAY, after index len-1 the pointer wraps to 0 and playback continues. A done pulse is issued at each wrap. Only play_pulse or clear_pulse exits PLAY.
- Undefined: playback is one-shot as described above.

Test Plan:
1. Params NUM_SLOTS=8, DEPTH=4. slot_sel=3, rec_pulse, then 2 ticks with note_in=0x11 and 0x22, then rec_pulse -> recording falls, no done pulse, cur_len(slot 3)=2.
2. slot_sel=3, play_pulse, then 2 ticks -> note_valid 1 cycle after each tick with note_out 0x11 then 0x22. done accompanies the 0x22 strobe, playing falls, then note_out=0.
3. slot_sel=5, rec_pulse, 5 ticks with note_in=1,2,3,4,5 -> after the 4th tick done=1 and state is IDLE. len[5]=4. The 5th tick writes nothing. Playback yields 1,2,3,4.
4. Simultaneous tick and rec_pulse in RECORD on slot 0 with note_in=0x7 -> sample stored, len increments, state IDLE. play_pulse on an empty slot 6 -> playing stays 0.
5. Slots 3 and 5 loaded, clear_pulse during PLAY of slot 5 -> playing=0, note_out=0, cur_len for slots 3 and 5 both 0 two cycles later.
6. resetn low mid-RECORD -> all outputs 0 asynchronously. With LOOP_PLAY_EN and a 2-note slot, 5 ticks -> notes A,B,A,B,A with done on each B.

Source files
------------

// File: rtl/beat_recorder_ctrl.sv
// beat_recorder_ctrl: multi-slot note recorder/player driven by a sample tick.
// Notes are stored in one RAM addressed {active_slot, ptr}. Each slot also has a
// length register. Playback reads the RAM with one cycle of latency.
// Optional build macro LOOP_PLAY_EN: playback wraps to the start of the slot and
// keeps going. When it is undefined, playback stops after the last stored note.
module beat_recorder_ctrl #(
  parameter int NUM_SLOTS = 8,
  parameter int DEPTH     = 256,
  parameter int NOTE_W    = 8
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         tick,
  input  logic                         rec_pulse,
  input  logic                         play_pulse,
  input  logic                         clear_pulse,
  input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
  input  logic [NOTE_W-1:0]            note_in,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         note_valid,
  output logic                         recording,
  output logic                         playing,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic [$clog2(DEPTH):0]       cur_len,
  output logic                         done
);

  localparam int SW        = $clog2(NUM_SLOTS);
  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = AW + 1;
  localparam int MEM_WORDS = NUM_SLOTS * DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [LW-1:0] ptr_reg, ptr_next;
  logic [SW-1:0] slot_reg, slot_next;
  logic          done_reg, done_next;
  logic          valid_reg, valid_next;
  logic          live_reg, live_next;    // note_out shows RAM data only while set
  logic [LW-1:0] cur_len_reg;

  logic mem_we;
  logic rd_en;
  logic len_clr_all;
  logic len_clr_sel;
  logic len_wr;

  logic [NUM_SLOTS-1:0][LW-1:0] len_all;
  logic [LW-1:0]                len_act;
  logic [LW-1:0]                len_sel;
  logic                         ptr_full;
  logic                         play_last;

  logic [NOTE_W-1:0]  mem [MEM_WORDS];
  logic [NOTE_W-1:0]  rd_data_reg;
  logic [SW+AW-1:0]   mem_addr;

  assign len_act   = len_all[slot_reg];
  assign len_sel   = len_all[slot_sel];
  assign ptr_full  = (ptr_reg == LW'(DEPTH - 1));
  assign play_last = ((ptr_reg + LW'(1)) == len_act);
  assign mem_addr  = {slot_reg, ptr_reg[AW-1:0]};

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and control decode; priority clear > rec > play in IDLE
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    slot_next   = slot_reg;
    done_next   = 1'b0;
    valid_next  = 1'b0;
    live_next   = 1'b0;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    len_clr_all = 1'b0;
    len_clr_sel = 1'b0;
    len_wr      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_pulse) begin
          state_next = ST_CLEAR;
        end else if (rec_pulse) begin
          state_next  = ST_RECORD;
          slot_next   = slot_sel;
          ptr_next    = '0;
          len_clr_sel = 1'b1;
        end else if (play_pulse && (len_sel != '0)) begin
          state_next = ST_PLAY;
          slot_next  = slot_sel;
          ptr_next   = '0;
        end
      end
      ST_RECORD: begin
        if (clear_pulse) begin
          state_next = ST_CLEAR;
        end else begin
          // A tick that arrives with rec_pulse still stores its sample
          if (tick) begin
            mem_we   = 1'b1;
            len_wr   = 1'b1;
            ptr_next = ptr_reg + LW'(1);
            if (ptr_full) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
          if (rec_pulse) state_next = ST_IDLE;
        end
      end
      ST_PLAY: begin
        live_next = live_reg;
        if (clear_pulse) begin
          state_next = ST_CLEAR;
          live_next  = 1'b0;
        end else if (play_pulse) begin
          state_next = ST_IDLE;
          live_next  = 1'b0;
        end else if (tick) begin
          rd_en      = 1'b1;
          valid_next = 1'b1;
          live_next  = 1'b1;
          ptr_next   = ptr_reg + LW'(1);
          if (play_last) begin
            done_next = 1'b1;
`ifdef LOOP_PLAY_EN
            ptr_next  = '0;
`else
            state_next = ST_IDLE;
`endif
          end
        end
      end
      ST_CLEAR: begin
        len_clr_all = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: pointer, latched slot, output strobes
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ptr_reg     <= '0;
      slot_reg    <= '0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      live_reg    <= 1'b0;
      cur_len_reg <= '0;
    end else begin
      ptr_reg     <= ptr_next;
      slot_reg    <= slot_next;
      done_reg    <= done_next;
      valid_reg   <= valid_next;
      live_reg    <= live_next;
      cur_len_reg <= len_sel;
    end
  end

  // Per-slot length registers
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_len
      logic [LW-1:0] len_reg;

      // Clear-all wins, then the clear at record start, then the record-tick update
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                                      len_reg <= '0;
        else if (len_clr_all)                             len_reg <= '0;
        else if (len_clr_sel && (slot_sel == SW'(gi)))    len_reg <= '0;
        else if (len_wr && (slot_reg == SW'(gi)))         len_reg <= ptr_reg + LW'(1);
      end

      assign len_all[gi] = len_reg;
    end
  endgenerate

  // Sample RAM with a registered read port; contents are never reset
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_addr] <= note_in;
    if (rd_en)  rd_data_reg   <= mem[mem_addr];
  end

  assign note_out    = live_reg ? rd_data_reg : '0;
  assign note_valid  = valid_reg;
  assign done        = done_reg;
  assign recording   = (state_reg == ST_RECORD);
  assign playing     = (state_reg == ST_PLAY);
  assign active_slot = slot_reg;
  assign cur_len     = cur_len_reg;

endmodule

// File: tb/tb_beat_recorder_ctrl.sv
// Bench for beat_recorder_ctrl (NUM_SLOTS=8, DEPTH=4). It uses directed steps
// and then random record/play/clear operations. These are checked against a
// per-slot note/length model.
module tb_beat_recorder_ctrl;
  localparam int NS = 8;
  localparam int D  = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0, rec_pulse = 1'b0, play_pulse = 1'b0, clear_pulse = 1'b0;
  logic [2:0] slot_sel = '0;
  logic [7:0] note_in = '0;
  logic [7:0] note_out;
  logic       note_valid, recording, playing, done;
  logic [2:0] active_slot;
  logic [2:0] cur_len;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] model_mem [NS][D];
  int         model_len [NS];
  logic [7:0] stim_q [$];

  beat_recorder_ctrl #(.NUM_SLOTS(NS), .DEPTH(D), .NOTE_W(8)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .tick(tick), .rec_pulse(rec_pulse),
    .play_pulse(play_pulse), .clear_pulse(clear_pulse), .slot_sel(slot_sel),
    .note_in(note_in), .note_out(note_out), .note_valid(note_valid),
    .recording(recording), .playing(playing), .active_slot(active_slot),
    .cur_len(cur_len), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_len(input int slot);
    slot_sel = 3'(slot);
    step();
    check("cur_len", 32'(cur_len), 32'(model_len[slot]));
  endtask

  // Record n ticks into slot; stop by rec_pulse (separate or with last tick) unless full
  task automatic do_record(input int slot, input int n, input bit tick_stop);
    bit ts, active, full;
    logic [7:0] nv;
    ts = tick_stop && (n < D);
    slot_sel = 3'(slot);
    rec_pulse = 1'b1;
    step();
    rec_pulse = 1'b0;
    check("rec_start", 32'(recording), 32'd1);
    check("rec_slot", 32'(active_slot), 32'(slot));
    model_len[slot] = 0;
    active = 1'b1;
    for (int i = 0; i < n; i++) begin
      nv = (stim_q.size() > 0) ? stim_q.pop_front() : 8'($urandom);
      note_in = nv;
      tick = 1'b1;
      if (ts && (i == n - 1)) rec_pulse = 1'b1;
      step();
      tick = 1'b0;
      rec_pulse = 1'b0;
      full = 1'b0;
      if (active) begin
        model_mem[slot][i] = nv;
        model_len[slot] = i + 1;
        if (i == D - 1) begin
          full = 1'b1;
          active = 1'b0;
        end
        if (ts && (i == n - 1)) active = 1'b0;
      end
      check("rec_done", 32'(done), 32'(full));
      check("rec_state", 32'(recording), 32'(active));
      if (active && (i < n - 1)) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          check("rec_gap_done", 32'(done), 32'd0);
        end
      end
    end
    if (active) begin
      rec_pulse = 1'b1;
      step();
      rec_pulse = 1'b0;
      check("rec_stop", 32'(recording), 32'd0);
      check("rec_stop_done", 32'(done), 32'd0);
    end
  endtask

  // Play nt ticks of slot; stop with play_pulse if still playing afterwards
  task automatic do_play(input int slot, input int nt);
    int idx;
    bit still, last;
    logic [7:0] prev;
    slot_sel = 3'(slot);
    play_pulse = 1'b1;
    step();
    play_pulse = 1'b0;
    if (model_len[slot] == 0) begin
      check("play_empty", 32'(playing), 32'd0);
      return;
    end
    check("play_start", 32'(playing), 32'd1);
    check("play_start_note", 32'(note_out), 32'd0);
    idx = 0;
    still = 1'b1;
    for (int k = 0; (k < nt) && still; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      last = (idx == model_len[slot] - 1);
      prev = model_mem[slot][idx];
      check("play_valid", 32'(note_valid), 32'd1);
      check("play_note", 32'(note_out), 32'(prev));
      check("play_done", 32'(done), 32'(last));
`ifdef LOOP_PLAY_EN
      idx = last ? 0 : idx + 1;
`else
      if (last) still = 1'b0;
      idx = idx + 1;
`endif
      check("play_state", 32'(playing), 32'(still));
      if (still && (k < nt - 1)) begin
        repeat ($urandom_range(0, 2)) begin
          step();
          check("play_gap_valid", 32'(note_valid), 32'd0);
          check("play_gap_hold", 32'(note_out), 32'(prev));
        end
      end
    end
    if (still) begin
      play_pulse = 1'b1;
      step();
      play_pulse = 1'b0;
      check("play_stop", 32'(playing), 32'd0);
      check("play_stop_done", 32'(done), 32'd0);
    end else begin
      step();
      check("play_end_valid", 32'(note_valid), 32'd0);
      check("play_end_done", 32'(done), 32'd0);
    end
    check("play_silence", 32'(note_out), 32'd0);
  endtask

  task automatic do_clear();
    clear_pulse = 1'b1;
    step();
    clear_pulse = 1'b0;
    check("clr_rec", 32'(recording), 32'd0);
    check("clr_play", 32'(playing), 32'd0);
    step();
    for (int s = 0; s < NS; s++) model_len[s] = 0;
  endtask

  initial begin
    int op, slot, n, len;
    for (int s = 0; s < NS; s++) model_len[s] = 0;

    // Reset state
    repeat (3) step();
    check("rst_note", 32'(note_out), 32'd0);
    check("rst_valid", 32'(note_valid), 32'd0);
    check("rst_rec", 32'(recording), 32'd0);
    check("rst_play", 32'(playing), 32'd0);
    check("rst_slot", 32'(active_slot), 32'd0);
    check("rst_len", 32'(cur_len), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    resetn = 1'b1;
    step();

    // Two notes into slot 3, stopped by rec_pulse
    stim_q = '{8'h11, 8'h22};
    do_record(3, 2, 1'b0);
    check_len(3);
    do_play(3, 2);

    // Slot 5 fills at 4 notes; the fifth tick is ignored
    stim_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    do_record(5, 5, 1'b0);
    check_len(5);
    do_play(5, 4);

    // Tick coincident with rec_pulse on slot 0; empty slot 6 will not play
    stim_q = '{8'h07};
    do_record(0, 1, 1'b1);
    check_len(0);
    do_play(6, 1);

    // Clear during playback of slot 5
    slot_sel = 3'd5;
    play_pulse = 1'b1;
    step();
    play_pulse = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("clr_pre_note", 32'(note_out), 32'd1);
    clear_pulse = 1'b1;
    step();
    clear_pulse = 1'b0;
    check("clr_playing", 32'(playing), 32'd0);
    check("clr_note", 32'(note_out), 32'd0);
    step();
    for (int s = 0; s < NS; s++) model_len[s] = 0;
    check_len(3);
    check_len(5);
    do_play(3, 1);

`ifdef LOOP_PLAY_EN
    // Two-note slot looped for five ticks: A,B,A,B,A
    stim_q = '{8'hA1, 8'hB2};
    do_record(1, 2, 1'b0);
    do_play(1, 5);
`endif

    // Randomized operations
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      slot = $urandom_range(0, NS - 1);
      if (op <= 3) begin
        n = $urandom_range(1, D + 1);
        do_record(slot, n, 1'($urandom_range(0, 1)));
      end else if (op <= 7) begin
        len = model_len[slot];
`ifdef LOOP_PLAY_EN
        n = $urandom_range(1, 2 * D + 1);
`else
        n = (len == 0) ? 1 : $urandom_range(1, len);
`endif
        do_play(slot, n);
      end else if (op == 8) begin
        do_clear();
      end else begin
        check_len(slot);
      end
    end

    // Asynchronous reset in the middle of a recording
    do_clear();
    slot_sel = 3'd2;
    rec_pulse = 1'b1;
    step();
    rec_pulse = 1'b0;
    note_in = 8'h5A;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("pre_rst_rec", 32'(recording), 32'd1);
    resetn = 1'b0;
    #2;
    check("arst_rec", 32'(recording), 32'd0);
    check("arst_slot", 32'(active_slot), 32'd0);
    check("arst_note", 32'(note_out), 32'd0);
    check("arst_valid", 32'(note_valid), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_len", 32'(cur_len), 32'd0);
    for (int s = 0; s < NS; s++) model_len[s] = 0;
    resetn = 1'b1;
    step();
    check_len(2);
    do_play(2, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
